// File: rtl/axi4_lite_register_bridge_if.sv
// AXI4-Lite channel bundle for the register bridge.
// The master drives requests and ready for the responses; the slave drives the rest.
interface axi4_lite_register_bridge_if #(
   parameter int N = 4,
   parameter int A = 32
);
   logic [A-1:0]   awaddr;
   logic           awvalid;
   logic           awready;
   logic [8*N-1:0] wdata;
   logic [N-1:0]   wstrb;
   logic           wvalid;
   logic           wready;
   logic [1:0]     bresp;
   logic           bvalid;
   logic           bready;
   logic [A-1:0]   araddr;
   logic           arvalid;
   logic           arready;
   logic [8*N-1:0] rdata;
   logic [1:0]     rresp;
   logic           rvalid;
   logic           rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4_lite_register_bridge.sv
// AXI4-Lite slave exposing MI registers: byte-strobed writes into register_out,
// reads sampled from register_in, with one-cycle wr_en/rd_en strobes.
module axi4_lite_register_bridge #(
   parameter int N  = 4,
   parameter int MW = 2,
   parameter int MI = 2**MW,
   parameter int A  = 32
) (
   input  logic                   aclk,
   input  logic                   reset,
   axi4_lite_register_bridge_if.slave axi,
   input  logic [MI-1:0][8*N-1:0] register_in,
   output logic [MI-1:0][8*N-1:0] register_out,
   output logic [MI-1:0]          wr_en,
   output logic [MI-1:0]          rd_en,
   output logic [8*N-1:0]         reg_wdata
);
   localparam int LB = $clog2(N);

   if (!(N == 4 || N == 8)) begin : g_bad_width
      $fatal(1, "axi4_lite_register_bridge: N must be 4 or 8");
   end

   typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_EXEC, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   wstate_e                 wstate_q, wstate_d;
   rstate_e                 rstate_q, rstate_d;
   logic [MW-1:0]           widx_q, widx_d;
   logic [8*N-1:0]          wdata_q, wdata_d;
   logic [N-1:0]            wstrb_q, wstrb_d;
   logic [MI-1:0][8*N-1:0]  regs_q, regs_d;
   logic [8*N-1:0]          reg_wdata_q, reg_wdata_d;
   logic [MW-1:0]           ridx_q, ridx_d;
   logic [8*N-1:0]          rdata_q, rdata_d;
   logic                    rpulse_q, rpulse_d;
   logic                    aw_ready, w_ready, b_valid, ar_ready, r_valid;
   logic [MW-1:0]           aw_idx, ar_idx;
   logic                    unused_addr_bits;

   assign aw_idx           = axi.awaddr[LB +: MW];
   assign ar_idx           = axi.araddr[LB +: MW];
   assign unused_addr_bits = ^{axi.awaddr, axi.araddr};

   always_comb begin
      wstate_d    = wstate_q;
      widx_d      = widx_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      regs_d      = regs_q;
      reg_wdata_d = reg_wdata_q;
      aw_ready    = 1'b0;
      w_ready     = 1'b0;
      b_valid     = 1'b0;
      wr_en       = '0;
      case (wstate_q)
         W_IDLE: begin
            aw_ready = 1'b1;
            w_ready  = 1'b1;
            if (axi.awvalid && axi.wvalid) wstate_d = W_EXEC;
            else if (axi.awvalid)          wstate_d = W_HAVE_AW;
            else if (axi.wvalid)           wstate_d = W_HAVE_W;
         end
         W_HAVE_AW: begin
            w_ready = 1'b1;
            if (axi.wvalid) wstate_d = W_EXEC;
         end
         W_HAVE_W: begin
            aw_ready = 1'b1;
            if (axi.awvalid) wstate_d = W_EXEC;
         end
         W_EXEC: begin
            for (int unsigned r = 0; r < MI; r++) begin
               if (widx_q == MW'(r)) begin
                  wr_en[r] = 1'b1;
                  for (int unsigned k = 0; k < N; k++) begin
                     if (wstrb_q[k]) regs_d[r][8*k +: 8] = wdata_q[8*k +: 8];
                  end
               end
            end
            reg_wdata_d = wdata_q;
            wstate_d    = W_RESP;
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (axi.bready) wstate_d = W_IDLE;
         end
         default: wstate_d = W_IDLE;
      endcase
      // Address and data are latched on their own handshake and held until W_EXEC.
      if (aw_ready && axi.awvalid) widx_d = aw_idx;
      if (w_ready && axi.wvalid) begin
         wdata_d = axi.wdata;
         wstrb_d = axi.wstrb;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         wstate_q    <= W_IDLE;
         widx_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         regs_q      <= '0;
         reg_wdata_q <= '0;
      end else begin
         wstate_q    <= wstate_d;
         widx_q      <= widx_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         regs_q      <= regs_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

   always_comb begin
      rstate_d = rstate_q;
      ridx_d   = ridx_q;
      rdata_d  = rdata_q;
      rpulse_d = 1'b0;
      ar_ready = (rstate_q == R_IDLE);
      r_valid  = (rstate_q == R_DATA);
      rd_en    = '0;
      case (rstate_q)
         R_IDLE: begin
            if (axi.arvalid) begin
               rstate_d = R_DATA;
               ridx_d   = ar_idx;
               rpulse_d = 1'b1;
               for (int unsigned r = 0; r < MI; r++) begin
                  if (ar_idx == MW'(r)) rdata_d = register_in[r];
               end
            end
         end
         R_DATA: if (axi.rready) rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
      for (int unsigned r = 0; r < MI; r++) begin
         if (rpulse_q && ridx_q == MW'(r)) rd_en[r] = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         rstate_q <= R_IDLE;
         ridx_q   <= '0;
         rdata_q  <= '0;
         rpulse_q <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         ridx_q   <= ridx_d;
         rdata_q  <= rdata_d;
         rpulse_q <= rpulse_d;
      end
   end

   assign axi.awready  = aw_ready;
   assign axi.wready   = w_ready;
   assign axi.bvalid   = b_valid;
   assign axi.bresp    = 2'b00;
   assign axi.arready  = ar_ready;
   assign axi.rvalid   = r_valid;
   assign axi.rresp    = 2'b00;
   assign axi.rdata    = rdata_q;
   assign register_out = regs_q;
   assign reg_wdata    = reg_wdata_q;
endmodule

// File: tb/tb_axi4_lite_register_bridge.sv
// Bench for axi4_lite_register_bridge: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a transaction-level model.
module tb_axi4_lite_register_bridge;
   localparam int N  = 4;
   localparam int MW = 2;
   localparam int MI = 4;
   localparam int A  = 32;

   logic                 aclk = 1'b0;
   logic                 reset;
   logic [MI-1:0][31:0]  register_in;
   logic [MI-1:0][31:0]  register_out;
   logic [MI-1:0]        wr_en;
   logic [MI-1:0]        rd_en;
   logic [31:0]          reg_wdata;

   int n_pass  = 0;
   int n_total = 0;

   axi4_lite_register_bridge_if #(.N(N), .A(A)) bus ();

   axi4_lite_register_bridge #(.N(N), .MW(MW), .MI(MI), .A(A)) dut (
      .aclk         (aclk),
      .reset        (reset),
      .axi          (bus),
      .register_in  (register_in),
      .register_out (register_out),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .reg_wdata    (reg_wdata)
   );

   always #5 aclk = ~aclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   // Transaction-level reference: pending-address/pending-data flags, one write
   // in flight, a byte-merged register image and a single outstanding read.
   bit          m_on = 1'b0;
   bit          m_aw, m_w, m_exec, m_resp;
   int          m_aidx;
   logic [31:0] m_wd;
   logic [3:0]  m_ws;
   logic [31:0] m_regs [MI];
   logic [31:0] m_last;
   bit          r_busy, r_pulse;
   int          r_idx;
   logic [31:0] r_data;

   always @(posedge aclk) begin : model
      bit awr, wrd;
      if (reset) begin
         m_on = 1'b1; m_aw = 0; m_w = 0; m_exec = 0; m_resp = 0; m_aidx = 0;
         m_wd = '0; m_ws = '0; m_last = '0;
         for (int i = 0; i < MI; i++) m_regs[i] = '0;
         r_busy = 0; r_pulse = 0; r_idx = 0; r_data = '0;
      end else begin
         awr = !m_aw && !m_exec && !m_resp;
         wrd = !m_w && !m_exec && !m_resp;
         if (m_exec) begin
            for (int k = 0; k < 4; k++)
               if (m_ws[k]) m_regs[m_aidx][8*k +: 8] = m_wd[8*k +: 8];
            m_last = m_wd;
            m_exec = 0; m_resp = 1; m_aw = 0; m_w = 0;
         end else if (m_resp) begin
            if (bus.bready) m_resp = 0;
         end else begin
            if (bus.awvalid && awr) begin m_aw = 1; m_aidx = int'(bus.awaddr[3:2]); end
            if (bus.wvalid && wrd) begin m_w = 1; m_wd = bus.wdata; m_ws = bus.wstrb; end
            if (m_aw && m_w) m_exec = 1;
         end
         r_pulse = 0;
         if (r_busy) begin
            if (bus.rready) r_busy = 0;
         end else if (bus.arvalid) begin
            r_busy = 1; r_pulse = 1;
            r_idx  = int'(bus.araddr[3:2]);
            r_data = register_in[r_idx];
         end
      end
   end

   always @(negedge aclk) begin
      if (m_on) begin
         chk("awready", bus.awready, !m_aw && !m_exec && !m_resp);
         chk("wready",  bus.wready,  !m_w && !m_exec && !m_resp);
         chk("bvalid",  bus.bvalid,  m_resp);
         chk("bresp",   bus.bresp,   0);
         chk("arready", bus.arready, !r_busy);
         chk("rvalid",  bus.rvalid,  r_busy);
         chk("rresp",   bus.rresp,   0);
         chk("rdata",   bus.rdata,   r_data);
         chk("wr_en",   wr_en,       m_exec ? (64'd1 << m_aidx) : 64'd0);
         chk("rd_en",   rd_en,       r_pulse ? (64'd1 << r_idx) : 64'd0);
         chk("reg_wdata", reg_wdata, m_last);
         for (int i = 0; i < MI; i++) chk("register_out", register_out[i], m_regs[i]);
      end
   end

   int wr1_cnt = 0, rd3_cnt = 0, wr_any_cnt = 0;
   always @(negedge aclk) begin
      if (wr_en[1]) wr1_cnt++;
      if (rd_en[3]) rd3_cnt++;
      if (wr_en != '0) wr_any_cnt++;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic wait_b(input string nm);
      int n = 0;
      while (!bus.bvalid && n < 50) begin tick(); n++; end
      chk(nm, bus.bvalid, 1);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      wait_b("write_bvalid");
   endtask

   initial begin
      int c;
      bit aw_hs, w_hs, ar_hs;
      reset = 1'b1;
      bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
      bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
      for (int i = 0; i < MI; i++) register_in[i] = $urandom;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge aclk);
      chk("reset_awready", bus.awready, 1);
      chk("reset_wready", bus.wready, 1);
      chk("reset_arready", bus.arready, 1);
      chk("reset_rdata", bus.rdata, 0);

      // single-cycle AW+W to index 2
      tick();
      bus.awaddr = 32'h8; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1;
      tick();
      bus.awvalid = 0; bus.wvalid = 0;
      @(negedge aclk);
      chk("d1_wr_en", wr_en, 4'b0100);
      chk("d1_bvalid_early", bus.bvalid, 0);
      tick();
      @(negedge aclk);
      chk("d1_bvalid", bus.bvalid, 1);
      chk("d1_reg2", register_out[2], 32'hDEADBEEF);
      tick();
      bus.bready = 1; tick(); bus.bready = 0;

      // W three cycles ahead of AW, partial strobe
      do_write(32'h4, 32'hAAAAAAAA, 4'hF);
      c = wr1_cnt;
      bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1;
      tick();
      bus.wvalid = 0;
      repeat (2) tick();
      bus.awaddr = 32'h4; bus.awvalid = 1;
      tick();
      bus.awvalid = 0;
      wait_b("d2_bvalid");
      @(negedge aclk);
      chk("d2_reg1", register_out[1], 32'hAAAA5678);
      chk("d2_wr1_pulses", wr1_cnt - c, 1);

      // read held under rready backpressure
      tick();
      register_in[3] = 32'hCAFEF00D;
      c = rd3_cnt;
      bus.araddr = 32'hC; bus.arvalid = 1;
      tick();
      bus.arvalid = 0;
      register_in[3] = 32'h0BADBEEF;
      repeat (5) begin
         @(negedge aclk);
         chk("d3_rvalid", bus.rvalid, 1);
         chk("d3_rdata", bus.rdata, 32'hCAFEF00D);
         tick();
      end
      chk("d3_rd3_pulses", rd3_cnt - c, 1);
      bus.rready = 1; tick(); bus.rready = 0;

      // B backpressure blocks a second AW
      bus.awaddr = 32'h0; bus.wdata = 32'h01020304; bus.wstrb = 4'hF;
      bus.awvalid = 1; bus.wvalid = 1;
      tick();
      bus.awvalid = 0; bus.wvalid = 0;
      tick();
      bus.awaddr = 32'h8; bus.awvalid = 1;
      repeat (10) tick();
      @(negedge aclk);
      chk("d4_bvalid_held", bus.bvalid, 1);
      chk("d4_awready_blocked", bus.awready, 0);
      chk("d4_wready_blocked", bus.wready, 0);
      tick();
      bus.bready = 1; tick(); bus.bready = 0;
      @(negedge aclk);
      chk("d4_awready_after_b", bus.awready, 1);
      tick();
      bus.awvalid = 0;
      bus.wdata = 32'h0A0B0C0D; bus.wstrb = 4'hF; bus.wvalid = 1;
      tick();
      bus.wvalid = 0;
      wait_b("d4_second_b");
      @(negedge aclk);
      chk("d4_reg2", register_out[2], 32'h0A0B0C0D);

      // simultaneous read and write of index 0
      tick();
      register_in[0] = 32'h11111111;
      bus.araddr = 32'h0; bus.awaddr = 32'h0; bus.wdata = 32'h55667788; bus.wstrb = 4'hF;
      bus.arvalid = 1; bus.awvalid = 1; bus.wvalid = 1;
      tick();
      bus.arvalid = 0; bus.awvalid = 0; bus.wvalid = 0;
      register_in[0] = 32'h22222222;
      wait_b("d5_bvalid");
      @(negedge aclk);
      chk("d5_rdata", bus.rdata, 32'h11111111);
      chk("d5_reg0", register_out[0], 32'h55667788);
      tick();
      bus.rready = 1; tick(); bus.rready = 0;

      // reset while an address is pending
      bus.awaddr = 32'h4; bus.awvalid = 1;
      tick();
      bus.awvalid = 0;
      c = wr_any_cnt;
      reset = 1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1;
      tick();
      reset = 0; bus.wvalid = 0;
      @(negedge aclk);
      chk("d6_awready", bus.awready, 1);
      chk("d6_wready", bus.wready, 1);
      chk("d6_arready", bus.arready, 1);
      chk("d6_bvalid", bus.bvalid, 0);
      for (int i = 0; i < MI; i++) chk("d6_reg_zero", register_out[i], 0);
      repeat (3) tick();
      chk("d6_no_wr_pulse", wr_any_cnt - c, 0);

      // random traffic; valids held until accepted
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge aclk);
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         ar_hs = bus.arvalid && bus.arready;
         tick();
         if (reset) reset = 0;
         else if ($urandom_range(0, 399) == 0) reset = 1;
         if (!bus.awvalid || aw_hs) begin
            bus.awvalid = ($urandom_range(0, 2) == 0);
            bus.awaddr  = $urandom;
         end
         if (!bus.wvalid || w_hs) begin
            bus.wvalid = ($urandom_range(0, 2) == 0);
            bus.wdata  = $urandom;
            bus.wstrb  = 4'($urandom);
         end
         if (!bus.arvalid || ar_hs) begin
            bus.arvalid = ($urandom_range(0, 2) == 0);
            bus.araddr  = $urandom;
         end
         bus.bready = ($urandom_range(0, 1) == 0);
         bus.rready = ($urandom_range(0, 1) == 0);
         register_in[$urandom_range(0, MI-1)] = $urandom;
      end
      reset = 0;
      bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
      bus.bready = 1; bus.rready = 1;
      repeat (5) tick();
      @(negedge aclk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
